// File: rtl/system_sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system ID / uptime / scratch register block.
// The master modport drives the request side; the slave modport returns read data.
interface system_sysid_regs_if #(
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/system_sysid_regs.sv
// System ID register file: ID, build timestamp, capabilities, a 64-bit uptime counter
// with a coherent high-word shadow, and NUM_SCRATCH byte-writable scratch words.
module system_sysid_regs #(
  parameter logic [31:0] SYS_ID        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int          NUM_SCRATCH   = 4,
  parameter int          ADDR_W        = 4,
  parameter logic [63:0] UPTIME_RESET  = 64'h0,
  parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
  input  logic                clock,
  input  logic                reset_n,
  system_sysid_regs_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_HI   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_CAPS = ADDR_W'(4);
  localparam int                SCR_BASE  = 5;
  localparam logic [31:0]       CAPS_WORD = {8'h01, 8'd0, 8'(ADDR_W), 8'(NUM_SCRATCH)};

  logic [63:0]                   uptime_reg;
  logic [31:0]                   hi_shadow_reg;
  logic [31:0]                   readdata_reg;
  logic                          readdatavalid_reg;
  logic [NUM_SCRATCH-1:0][31:0]  scratch_q;
  logic [31:0]                   rd_word;
  logic                          rd_accept;
  logic                          lo_clear;
  logic                          lo_capture;

  // A write in the same cycle as a read takes priority; the read is dropped.
  assign rd_accept  = bus.read && !bus.write;
  assign lo_clear   = bus.write && (bus.address == ADDR_LO);
  assign lo_capture = rd_accept && (bus.address == ADDR_LO);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime_reg    <= UPTIME_RESET;
      hi_shadow_reg <= 32'h0;
    end else begin
      if (lo_clear) begin
        uptime_reg <= 64'h0;
      end else begin
        uptime_reg <= uptime_reg + 64'd1;
      end
      if (lo_capture) begin
        hi_shadow_reg <= uptime_reg[63:32];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      logic [31:0] word_reg;
      logic        word_sel;

      assign word_sel = bus.write && (bus.address == ADDR_W'(SCR_BASE + gi));

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          word_reg <= SCRATCH_RESET;
        end else if (word_sel) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) begin
              word_reg[b*8 +: 8] <= bus.writedata[b*8 +: 8];
            end
          end
        end
      end

      assign scratch_q[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    rd_word = 32'h0;
    case (bus.address)
      ADDR_ID:   rd_word = SYS_ID;
      ADDR_TS:   rd_word = TIMESTAMP;
      ADDR_LO:   rd_word = uptime_reg[31:0];
      ADDR_HI:   rd_word = hi_shadow_reg;
      ADDR_CAPS: rd_word = CAPS_WORD;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (bus.address == ADDR_W'(SCR_BASE + i)) begin
            rd_word = scratch_q[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata_reg      <= 32'h0;
      readdatavalid_reg <= 1'b0;
    end else begin
      readdatavalid_reg <= rd_accept;
      if (rd_accept) begin
        readdata_reg <= rd_word;
      end
    end
  end

  assign bus.readdata      = readdata_reg;
  assign bus.readdatavalid = readdatavalid_reg;

endmodule
